// File: rtl/cla_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial carry-lookahead adder.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // Ceiling log2 with a floor of one bit so a single-step counter still exists.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    if (result < 1) begin
      result = 1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/cla_seq_ctrl_if.sv
// Operand/result handshake bundle for cla_seq_ctrl; master = producer/consumer, slave = sequencer.
interface cla_seq_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/cla_seq_ctrl_cla.sv
// Four-bit carry-lookahead adder; all carries are flattened two-level generate/propagate terms.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] so,
  output logic       co
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  always_comb begin
    g_s    = a & b;
    p_s    = a ^ b;
    c_s[0] = cin;
    c_s[1] = g_s[0] | (p_s[0] & cin);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & cin);
    c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
    so     = p_s ^ c_s[3:0];
    co     = c_s[4];
  end

endmodule

// File: rtl/cla_seq_ctrl.sv
// Wide adder built from one 4-bit CLA reused LSB-nibble first, with valid/ready on both sides.
// Define CLA_SEQ_SUB_EN to honour the sub input (two's-complement subtract); otherwise add-only.
module cla_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  cla_seq_ctrl_if.slave  bus
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = clog2(NIB);

  state_t             state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   sum_r;
  logic               carry_r;
  logic               cout_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               out_valid_r;
  logic               busy_r;

  logic [NIB_W-1:0]   so_s;
  logic               co_s;
  logic [WIDTH-1:0]   acc_next_s;
  logic [WIDTH-1:0]   b_load_s;
  logic               carry_load_s;
  logic               last_step_s;

  cla u_cla (
    .a   (a_r[NIB_W-1:0]),
    .b   (b_r[NIB_W-1:0]),
    .cin (carry_r),
    .so  (so_s),
    .co  (co_s)
  );

  // New nibble enters from the top so the first one lands at bit 0 after NIB steps.
  generate
    if (WIDTH == NIB_W) begin : g_single
      assign acc_next_s = so_s;
    end else begin : g_multi
      assign acc_next_s = {so_s, acc_r[WIDTH-1:NIB_W]};
    end
  endgenerate

  logic [NIB_W-1:0] unused_acc_s;
  assign unused_acc_s = acc_r[NIB_W-1:0];

  assign last_step_s = (cnt_r == CNT_W'(NIB - 1));

`ifdef CLA_SEQ_SUB_EN
  logic unused_sub_s;
  assign unused_sub_s = 1'b0;

  // Subtract is a + ~b + 1; cin is overridden so the +1 is always present.
  always_comb begin
    b_load_s     = bus.b;
    carry_load_s = bus.cin;
    if (bus.sub) begin
      b_load_s     = ~bus.b;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = bus.b;
      carry_load_s = bus.cin;
    end
  end
`else
  logic unused_sub_s;
  assign unused_sub_s = bus.sub;

  // Add-only datapath: operands load unchanged.
  always_comb begin
    b_load_s     = bus.b;
    carry_load_s = bus.cin;
  end
`endif

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.busy      = busy_r;

  // Controller FSM with its shift datapath; result registers only update on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      acc_r       <= '0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.a;
            b_r     <= b_load_s;
            carry_r <= carry_load_s;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_r >> NIB_W;
          b_r     <= b_r >> NIB_W;
          acc_r   <= acc_next_s;
          carry_r <= co_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_step_s) begin
            sum_r       <= acc_next_s;
            cout_r      <= co_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cla_seq_ctrl.md
Name: cla_seq_ctrl

Overview:
Sequencer that adds two WIDTH-bit operands by time-multiplexing one 4-bit carry-lookahead adder (cla), one nibble per cycle, LSB first.
- Carry is held in a register between nibbles.
- Valid/ready handshake on both input and output sides.
- Sits between operand producers and result consumers wherever wide adds are needed without a wide adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NIB, WIDTH/4, number of nibble steps (derived localparam, not overridable)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operands a, b, cin, sub present
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in to nibble 0
sub  in  1  subtract request; ignored unless CLA_SEQ_SUB_EN is defined
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result, mod 2^WIDTH
cout  out  1  carry out of MSB nibble
busy  out  1  high in RUN or DONE

Behaviour:
- One clock (clk); reset rst is asynchronous, active-high. Reset forces state=IDLE, sum=0, cout=0, out_valid=0, busy=0, carry_reg=0, cnt=0. in_ready=1 while reset is asserted and after release.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture a→a_reg, b→b_reg, cin→carry_reg, cnt←0, then go to RUN.
  - RUN: drive cla with a_reg[3:0], b_reg[3:0], carry_reg. On each edge:
    - right-shift a_reg and b_reg by 4;
    - shift cla.so into sum_reg from the top (sum_reg ← {so, sum_reg[WIDTH-1:4]});
    - carry_reg ← co; cnt++.
    - When cnt==NIB-1, go to DONE.
  - DONE: out_valid=1. sum and cout are driven from registers and held stable until out_ready. On out_valid&out_ready, go to IDLE.
- Latency: if the accept edge is k, out_valid rises after edge k+NIB. WIDTH=4 gives a single RUN cycle.
- in_ready is a combinational decode of state==IDLE. There is no same-cycle accept in DONE; a new operand is accepted at the earliest one cycle after the output handshake.
- in_valid during RUN or DONE is ignored, and the inputs are not sampled.
- out_ready high outside DONE has no effect.
- sum and cout keep their last result in IDLE until the next result overwrites them. They are not cleared on handshake.
- Assertion of rst mid-RUN or mid-DONE aborts the operation immediately. No out_valid is produced.
- Arithmetic: sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.

Optional Feature:
CLA_SEQ_SUB_EN
- Defined: sub is captured at accept. If sub=1, then b_reg←~b and carry_reg←1 (cin ignored), giving sum = (a − b) mod 2^WIDTH. cout=1 means no borrow (a≥b).
- Not defined: sub is ignored and the datapath is add-only; the port remains for a stable interface.

Decomposition:
- Package cla_seq_pkg:
  - state enum IDLE/RUN/DONE (2-bit encoding);
  - NIB_W constant = 4;
  - function clog2 for sizing the cnt register.
- One sub-module: cla, the existing 4-bit carry-lookahead adder, instantiated once (a, b, cin, so, co).
- Controller FSM, shift registers and carry register all live in cla_seq_ctrl.

Test Plan:
1. WIDTH=16, after reset: a=0x0001, b=0x0007, cin=1 → sum=0x0009, cout=0. out_valid rises exactly 4 edges after accept.
2. a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1 (carry ripples across all 4 nibble steps).
3. a=0x5A5A, b=0xA5A5, cin=0 → sum=0xFFFF, cout=0. Repeat with cin=1 → sum=0x0000, cout=1.
4. Backpressure: out_ready low for 5 cycles in DONE → sum/cout stable, in_ready=0, and a concurrent in_valid with new operands is ignored. After the handshake, in_ready=1 on the next cycle and the next operation (0x0003+0x0004) gives 0x0007.
5. rst pulsed at the 2nd RUN cycle → out_valid=0, busy=0 and in_ready=1 asynchronously, with no result emitted. A fresh add afterward gives the correct result.
6. With CLA_SEQ_SUB_EN, sub=1:
   - a=0x0005, b=0x000A → sum=0xFFFB, cout=0;
   - a=0x000A, b=0x0005 → sum=0x0005, cout=1.
   Without the macro, the same stimulus with sub=1 gives add results (0x000F, cout=0).
